psum_decoder: RTL and testbench

PSUM_DECODER -- requirements
Module: psum_decoder

---
 rtl/psum_decoder_pkg.sv | 10 +
 rtl/psum_decoder_if.sv | 17 +
 rtl/psum_decoder_src_match.sv | 21 ++
 rtl/psum_decoder.sv | 81 ++++++++
 tb/tb_psum_decoder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/psum_decoder_pkg.sv
// psum_decoder_pkg: FSM state type and packet field offsets shared by the decoder files
package psum_decoder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DROP = 2'd2} state_e;
  function automatic int src_lo(input int addr_w);
    return addr_w;
  endfunction
  function automatic int psum_lo(input int addr_w, input int psum_w, input int i);
    return 2 * addr_w + i * psum_w;
  endfunction
endpackage

// File: rtl/psum_decoder_if.sv
// psum_decoder_if: packet input handshake and per-PE psum output channels
interface psum_decoder_if #(
  parameter int PKT_W  = 39,
  parameter int PSUM_W = 8,
  parameter int NUM_PE = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PKT_W-1:0]         in_pkt;
  logic [NUM_PE-1:0]        out_valid;
  logic [NUM_PE-1:0]        out_ready;
  logic [NUM_PE*PSUM_W-1:0] out_data;
  logic                     out_last;
  logic                     err_pulse;
  modport master (output in_valid, in_pkt, out_ready, input in_ready, out_valid, out_data, out_last, err_pulse);
  modport slave (input in_valid, in_pkt, out_ready, output in_ready, out_valid, out_data, out_last, err_pulse);
endinterface

// File: rtl/psum_decoder_src_match.sv
// psum_decoder_src_match: maps a source address to the lowest-index PE that owns it
module psum_decoder_src_match #(
  parameter int ADDR_W = 4,
  parameter int NUM_PE = 3,
  parameter logic [NUM_PE*ADDR_W-1:0] PE_SRC_ADDR = {4'd0, 4'd1, 4'd4},
  localparam int TGT_W = NUM_PE > 1 ? $clog2(NUM_PE) : 1
) (
  input  logic [ADDR_W-1:0] src,
  output logic              hit,
  output logic [TGT_W-1:0]  idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_PE - 1; k >= 0; k--)
      if (PE_SRC_ADDR[k*ADDR_W +: ADDR_W] == src) begin
        hit = 1'b1;
        idx = TGT_W'(k);
      end
  end
endmodule

// File: rtl/psum_decoder.sv
// psum_decoder: routes each packet's psums, one per cycle, to the PE whose source address matches
// Optional err_cnt output enabled by defining PSUM_DECODER_ERR_CNT_EN.
module psum_decoder
  import psum_decoder_pkg::*;
#(
  parameter int PKT_W        = 39,
  parameter int ADDR_W       = 4,
  parameter int PSUM_W       = 8,
  parameter int PSUM_PER_PKT = 3,
  parameter int NUM_PE       = 3,
  parameter logic [NUM_PE*ADDR_W-1:0] PE_SRC_ADDR = {4'd0, 4'd1, 4'd4}
) (
  input logic clk,
  input logic rst,
  psum_decoder_if.slave bus
`ifdef PSUM_DECODER_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);
  localparam int TGT_W = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
  localparam int IDX_W = PSUM_PER_PKT > 1 ? $clog2(PSUM_PER_PKT) : 1;
  if (2 * ADDR_W + PSUM_PER_PKT * PSUM_W > PKT_W || PSUM_PER_PKT < 1 || NUM_PE < 1) begin : g_bad_params
    $fatal(1, "psum_decoder: packet fields do not fit or counts are zero");
  end
  state_e            state;
  logic [PKT_W-1:0]  pkt;
  logic [IDX_W-1:0]  idx;
  logic [TGT_W-1:0]  tgt;
  logic [TGT_W-1:0]  hit_idx;
  logic              hit;
  logic              send;
  logic              last;
  logic              fire;
  logic [PSUM_W-1:0] psum;
  psum_decoder_src_match #(
    .ADDR_W(ADDR_W),
    .NUM_PE(NUM_PE),
    .PE_SRC_ADDR(PE_SRC_ADDR)
  ) u_match (
    .src(bus.in_pkt[src_lo(ADDR_W) +: ADDR_W]),
    .hit(hit),
    .idx(hit_idx)
  );
  always_comb begin
    send           = state == SEND;
    last           = idx == IDX_W'(PSUM_PER_PKT - 1);
    fire           = send && bus.out_ready[tgt];
    psum           = PSUM_W'(pkt >> psum_lo(ADDR_W, PSUM_W, int'(idx)));
    bus.in_ready   = state == IDLE;
    bus.err_pulse  = state == DROP;
    bus.out_last   = send && last;
    bus.out_valid  = send ? NUM_PE'(1) << tgt : '0;
    bus.out_data   = send ? (NUM_PE*PSUM_W)'(psum) << (int'(tgt) * PSUM_W) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pkt   <= '0;
      idx   <= '0;
      tgt   <= '0;
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          pkt   <= bus.in_pkt;
          idx   <= '0;
          tgt   <= hit_idx;
          state <= hit ? SEND : DROP;
        end
        SEND: if (fire) begin
          idx <= idx + IDX_W'(1);
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef PSUM_DECODER_ERR_CNT_EN
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (state == DROP && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_psum_decoder.sv
// tb_psum_decoder: directed checks of routing, backpressure, drop, reset and a wider parameter set
module tb_psum_decoder;
  logic clk = 1'b0;
  logic rst;
  int   n_run = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  psum_decoder_if #(.PKT_W(39), .PSUM_W(8), .NUM_PE(3)) b0 ();
  psum_decoder_if #(.PKT_W(48), .PSUM_W(8), .NUM_PE(5)) b1 ();
`ifdef PSUM_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt0;
  logic [15:0] err_cnt1;
`endif
  psum_decoder dut0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
`ifdef PSUM_DECODER_ERR_CNT_EN
    , .err_cnt(err_cnt0)
`endif
  );
  psum_decoder #(
    .PKT_W(48), .ADDR_W(4), .PSUM_W(8), .PSUM_PER_PKT(4), .NUM_PE(5),
    .PE_SRC_ADDR(20'h88765)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
`ifdef PSUM_DECODER_ERR_CNT_EN
    , .err_cnt(err_cnt1)
`endif
  );
  function automatic logic [38:0] pk3(input logic [3:0] src, input logic [3:0] dest,
                                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {7'd0, c, b, a, src, dest};
  endfunction
  function automatic logic [47:0] pk4(input logic [3:0] src, input logic [3:0] dest,
                                      input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return {8'd0, d, c, b, a, src, dest};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    b0.in_valid = 1'b0; b0.in_pkt = '0; b0.out_ready = '0;
    b1.in_valid = 1'b0; b1.in_pkt = '0; b1.out_ready = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", b0.in_ready, 1);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out_data", b0.out_data, 0);
    chk("rst_out_last", b0.out_last, 0);
    chk("rst_err", b0.err_pulse, 0);
`ifdef PSUM_DECODER_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt0, 0);
`endif
    // src=4 -> channel 0, full throughput
    b0.out_ready = 3'b111;
    b0.in_pkt = pk3(4'd4, 4'hA, 8'd10, 8'd20, 8'd30);
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk("a_valid0", b0.out_valid, 3'b001);
    chk("a_data0", b0.out_data, 24'd10);
    chk("a_last0", b0.out_last, 0);
    chk("a_ready0", b0.in_ready, 0);
    tick();
    chk("a_valid1", b0.out_valid, 3'b001);
    chk("a_data1", b0.out_data, 24'd20);
    chk("a_last1", b0.out_last, 0);
    tick();
    chk("a_data2", b0.out_data, 24'd30);
    chk("a_last2", b0.out_last, 1);
    tick();
    chk("a_ready_again", b0.in_ready, 1);
    chk("a_valid_idle", b0.out_valid, 0);
    // src=1 -> channel 1, backpressure on psum 6 (other channels' ready ignored)
    b0.in_pkt = pk3(4'd1, 4'h3, 8'd5, 8'd6, 8'd7);
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk("b_valid0", b0.out_valid, 3'b010);
    chk("b_data0", b0.out_data, 24'h000500);
    tick();
    chk("b_data1", b0.out_data, 24'h000600);
    b0.out_ready = 3'b101;
    tick();
    chk("b_hold1", b0.out_data, 24'h000600);
    chk("b_hold1_last", b0.out_last, 0);
    tick();
    chk("b_hold2", b0.out_data, 24'h000600);
    chk("b_hold2_valid", b0.out_valid, 3'b010);
    b0.out_ready = 3'b111;
    tick();
    chk("b_data2", b0.out_data, 24'h000700);
    chk("b_last2", b0.out_last, 1);
    tick();
    chk("b_idle", b0.in_ready, 1);
    // unmatched src=7 -> one DROP cycle, then src=0 -> channel 2
    b0.in_pkt = pk3(4'd7, 4'd0, 8'd9, 8'd9, 8'd9);
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk("c_err", b0.err_pulse, 1);
    chk("c_valid", b0.out_valid, 0);
    chk("c_data", b0.out_data, 0);
    chk("c_ready", b0.in_ready, 0);
    tick();
    chk("c_err_off", b0.err_pulse, 0);
    chk("c_ready1", b0.in_ready, 1);
`ifdef PSUM_DECODER_ERR_CNT_EN
    chk("c_err_cnt", err_cnt0, 1);
`endif
    b0.in_pkt = pk3(4'd0, 4'h7, 8'd1, 8'd2, 8'd3);
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk("c_valid2", b0.out_valid, 3'b100);
    chk("c_data0", b0.out_data, 24'h010000);
    tick();
    chk("c_data1", b0.out_data, 24'h020000);
    tick();
    chk("c_data2", b0.out_data, 24'h030000);
    chk("c_last2", b0.out_last, 1);
    tick();
    // reset mid-packet discards the rest
    b0.in_pkt = pk3(4'd4, 4'd1, 8'h11, 8'h22, 8'h33);
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk("d_data0", b0.out_data, 24'h000011);
    rst = 1'b1;
    tick();
    chk("d_valid", b0.out_valid, 0);
    chk("d_data", b0.out_data, 0);
    chk("d_last", b0.out_last, 0);
    chk("d_err", b0.err_pulse, 0);
    chk("d_ready", b0.in_ready, 1);
    rst = 1'b0;
    tick();
    chk("d_after1", b0.out_valid, 0);
    tick();
    chk("d_after2", b0.out_valid, 0);
    // back-to-back with in_valid held high: src 0, 4, 1
    b0.in_pkt = pk3(4'd0, 4'd5, 8'h41, 8'h42, 8'h43);
    b0.in_valid = 1'b1;
    tick();
    b0.in_pkt = pk3(4'd4, 4'd6, 8'h51, 8'h52, 8'h53);
    chk("e_valid0", b0.out_valid, 3'b100);
    chk("e_data0", b0.out_data, 24'h410000);
    chk("e_ready0", b0.in_ready, 0);
    tick();
    chk("e_ready0b", b0.in_ready, 0);
    tick();
    tick();
    chk("e_gap_ready", b0.in_ready, 1);
    chk("e_gap_valid", b0.out_valid, 0);
    tick();
    b0.in_pkt = pk3(4'd1, 4'd7, 8'h61, 8'h62, 8'h63);
    chk("e_valid1", b0.out_valid, 3'b001);
    chk("e_data1", b0.out_data, 24'h000051);
    chk("e_ready1", b0.in_ready, 0);
    tick();
    tick();
    tick();
    tick();
    b0.in_valid = 1'b0;
    chk("e_valid2", b0.out_valid, 3'b010);
    chk("e_data2", b0.out_data, 24'h006100);
    tick();
    tick();
    chk("e_data2_last", b0.out_data, 24'h006300);
    chk("e_last2", b0.out_last, 1);
    tick();
    chk("e_idle", b0.in_ready, 1);
    // wide variant: src=8 matches PE3 and PE4, lowest index wins
    b1.out_ready = 5'b11111;
    b1.in_pkt = pk4(4'd8, 4'd2, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    b1.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    chk("f_valid0", b1.out_valid, 5'b01000);
    chk("f_data0", b1.out_data, 40'h00A1000000);
    tick();
    chk("f_data1", b1.out_data, 40'h00A2000000);
    tick();
    chk("f_data2", b1.out_data, 40'h00A3000000);
    chk("f_last2", b1.out_last, 0);
    tick();
    chk("f_data3", b1.out_data, 40'h00A4000000);
    chk("f_last3", b1.out_last, 1);
    tick();
    chk("f_ready", b1.in_ready, 1);
    chk("f_valid_idle", b1.out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
